// File: rtl/shreg_pkg.sv
// shreg_pkg: shared types and constants for the multi-channel shift register
// Contents: burst FSM state enum, shift direction encodings.
package shreg_pkg;
   typedef enum logic {ST_IDLE, ST_RUN} state_t;
   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;
endpackage

// File: rtl/shreg_lane.sv
// shreg_lane: one WIDTH-bit shift register lane with parallel load
// Ports: clk, rst (sync, active-high); load, d (parallel load, wins over step);
//        step (shift one position), dir (0 right / 1 left), fill (bit entering);
//        q (contents), exit_bit (bit leaving on a shift in the current direction).
module shreg_lane
   import shreg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             step,
   input  logic             dir,
   input  logic             fill,
   output logic [WIDTH-1:0] q,
   output logic             exit_bit
);
   assign exit_bit = (dir == DIR_LEFT) ? q[WIDTH-1] : q[0];
   always_ff @(posedge clk) begin
      if (rst)
         q <= '0;
      else if (load)
         q <= d;
      else if (step)
         q <= (dir == DIR_RIGHT) ? {fill, q[WIDTH-1:1]} : {q[WIDTH-2:0], fill};
   end
endmodule

// File: rtl/multi_channel_shift_register.sv
// multi_channel_shift_register: NUM_CH independent shift lanes with cascade and burst engine
// Ports: clk, rst (sync, active-high); load/data (per-channel parallel load, channel i
//        at data[i*WIDTH +: WIDTH]); shift (single-step enables, also burst mask);
//        dir (0 right / 1 left); cascade_en, serial_in (chain fill); burst_start,
//        burst_len (clamped to WIDTH); out (contents); serial_out (last channel exit bit);
//        busy (burst running); done (one-cycle pulse at burst end).
// Option: define SHREG_ROTATE_EN to add input rotate (self-fill when cascade_en=0).
module multi_channel_shift_register
   import shreg_pkg::*;
#(
   parameter  int NUM_CH = 2,
   parameter  int WIDTH  = 8,
   localparam int CW     = $clog2(WIDTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       load,
   input  logic [NUM_CH*WIDTH-1:0] data,
   input  logic [NUM_CH-1:0]       shift,
   input  logic [NUM_CH-1:0]       dir,
   input  logic                    cascade_en,
   input  logic                    serial_in,
   input  logic                    burst_start,
   input  logic [CW-1:0]           burst_len,
`ifdef SHREG_ROTATE_EN
   input  logic                    rotate,
`endif
   output logic [NUM_CH*WIDTH-1:0] out,
   output logic                    serial_out,
   output logic                    busy,
   output logic                    done
);
   state_t            state;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     len_c;
   logic [NUM_CH-1:0] mask;
   logic [NUM_CH-1:0] step;
   logic [NUM_CH-1:0] exits;
   logic [NUM_CH-1:0] fills;
   logic              rot;
`ifdef SHREG_ROTATE_EN
   assign rot = rotate;
`else
   assign rot = 1'b0;
`endif
   assign len_c      = (burst_len > CW'(WIDTH)) ? CW'(WIDTH) : burst_len;
   // the cycle that captures a burst performs no single-step shift
   assign step       = (state == ST_RUN) ? mask : (burst_start ? '0 : shift);
   assign serial_out = exits[NUM_CH-1];
   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
         if (i == 0) begin : g_head
            assign fills[i] = cascade_en ? serial_in : (rot & exits[i]);
         end else begin : g_link
            assign fills[i] = cascade_en ? exits[i-1] : (rot & exits[i]);
         end
         shreg_lane #(.WIDTH(WIDTH)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .load     (load[i]),
            .d        (data[i*WIDTH +: WIDTH]),
            .step     (step[i]),
            .dir      (dir[i]),
            .fill     (fills[i]),
            .q        (out[i*WIDTH +: WIDTH]),
            .exit_bit (exits[i])
         );
      end
   endgenerate
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         mask  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == ST_IDLE) begin
            if (burst_start) begin
               mask  <= shift;
               cnt   <= len_c;
               busy  <= (len_c != '0);
               done  <= (len_c == '0);
               state <= (len_c != '0) ? ST_RUN : ST_IDLE;
            end
         end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_multi_channel_shift_register.sv
// tb_multi_channel_shift_register: directed vectors plus a behavioural model checked every cycle
module tb_multi_channel_shift_register;
   localparam int NUM_CH = 2;
   localparam int WIDTH  = 8;
`ifdef SHREG_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif
   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_CH-1:0]       load;
   logic [NUM_CH*WIDTH-1:0] data;
   logic [NUM_CH-1:0]       shift;
   logic [NUM_CH-1:0]       dir;
   logic                    cascade_en;
   logic                    serial_in;
   logic                    burst_start;
   logic [3:0]              burst_len;
   logic                    rotate;
   logic [NUM_CH*WIDTH-1:0] out;
   logic                    serial_out;
   logic                    busy;
   logic                    done;
   int n_chk  = 0;
   int n_pass = 0;
   always #5 clk = ~clk;
   multi_channel_shift_register #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .data        (data),
      .shift       (shift),
      .dir         (dir),
      .cascade_en  (cascade_en),
      .serial_in   (serial_in),
      .burst_start (burst_start),
      .burst_len   (burst_len),
`ifdef SHREG_ROTATE_EN
      .rotate      (rotate),
`endif
      .out         (out),
      .serial_out  (serial_out),
      .busy        (busy),
      .done        (done)
   );
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask
   // model: channel values as integers, burst as "shifts remaining"
   int              m_val [NUM_CH];
   int              m_nxt [NUM_CH];
   int              m_ex  [NUM_CH];
   int              m_rem = 0;
   logic [NUM_CH-1:0] m_mask = '0;
   bit              m_done = 0;
   bit              m_valid = 0;
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) m_val[i] = 0;
         m_rem = 0; m_mask = '0; m_done = 0; m_valid = 1;
      end else begin
         logic [NUM_CH-1:0] act;
         int f;
         int n;
         for (int i = 0; i < NUM_CH; i++)
            m_ex[i] = dir[i] ? (m_val[i] >> (WIDTH - 1)) & 1 : m_val[i] & 1;
         act = (m_rem > 0) ? m_mask : (burst_start ? '0 : shift);
         for (int i = 0; i < NUM_CH; i++) begin
            if (cascade_en) f = (i == 0) ? int'(serial_in) : m_ex[(i == 0) ? 0 : i - 1];
            else if (ROT && rotate) f = m_ex[i];
            else f = 0;
            if (load[i]) m_nxt[i] = int'(data[i*WIDTH +: WIDTH]);
            else if (act[i] && dir[i]) m_nxt[i] = ((m_val[i] * 2) % (1 << WIDTH)) + f;
            else if (act[i]) m_nxt[i] = (m_val[i] / 2) + f * (1 << (WIDTH - 1));
            else m_nxt[i] = m_val[i];
         end
         for (int i = 0; i < NUM_CH; i++) m_val[i] = m_nxt[i];
         m_done = 0;
         if (m_rem > 0) begin
            m_rem--;
            m_done = (m_rem == 0);
         end else if (burst_start) begin
            n = (int'(burst_len) > WIDTH) ? WIDTH : int'(burst_len);
            m_mask = shift;
            m_rem = n;
            m_done = (n == 0);
         end
      end
   end
   always @(negedge clk) begin
      if (m_valid) begin
         logic [NUM_CH*WIDTH-1:0] exp_out;
         int last;
         for (int i = 0; i < NUM_CH; i++) exp_out[i*WIDTH +: WIDTH] = m_val[i][WIDTH-1:0];
         last = dir[NUM_CH-1] ? (m_val[NUM_CH-1] >> (WIDTH - 1)) & 1 : m_val[NUM_CH-1] & 1;
         check("model_out", 64'(out), 64'(exp_out));
         check("model_serial_out", 64'(serial_out), 64'(last));
         check("model_busy", 64'(busy), 64'(m_rem > 0));
         check("model_done", 64'(done), 64'(m_done));
      end
   end
   task automatic clr();
      load = '0; data = '0; shift = '0; dir = '0; cascade_en = 1'b0; serial_in = 1'b0;
      burst_start = 1'b0; burst_len = '0; rotate = 1'b0;
   endtask
   task automatic do_load(input logic [1:0] m, input logic [15:0] d);
      load = m; data = d; @(negedge clk); load = '0;
   endtask
   task automatic run_burst(input logic [3:0] len, input logic [1:0] m, output int bc, output int dc);
      burst_start = 1'b1; burst_len = len; shift = m;
      @(negedge clk);
      burst_start = 1'b0; shift = '0; bc = 0; dc = 0;
      for (int k = 0; k < 20; k++) begin
         if (busy) bc++;
         if (done) dc++;
         @(negedge clk);
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end
   initial begin
      int bc, dc;
      clr();
      rst = 1'b1;
      repeat (2) begin
         load = NUM_CH'($urandom); data = 16'($urandom); shift = NUM_CH'($urandom);
         dir = NUM_CH'($urandom); burst_start = 1'($urandom); burst_len = 4'($urandom);
         @(negedge clk);
      end
      check("reset_out", 64'(out), 64'h0);
      check("reset_serial_out", 64'(serial_out), 64'h0);
      check("reset_busy", 64'(busy), 64'h0);
      check("reset_done", 64'(done), 64'h0);
      rst = 1'b0; clr();
      do_load(2'b11, 16'h55AA);
      check("load_both", 64'(out), 64'h55AA);
      shift = 2'b11; @(negedge clk); shift = '0;
      check("shift_right_zero_fill", 64'(out), 64'h2A55);
      do_load(2'b11, 16'h0001);
      serial_in = 1'b1; cascade_en = 1'b1; shift = 2'b11; @(negedge clk);
      check("cascade_out", 64'(out), 64'h8080);
      check("cascade_serial_out", 64'(serial_out), 64'h0);
      clr();
      do_load(2'b01, 16'h0081);
      shift = 2'b01; dir = 2'b01; @(negedge clk); clr();
      check("left_ch0", 64'(out[7:0]), 64'h02);
      do_load(2'b10, 16'hF000);
      run_burst(4'd4, 2'b10, bc, dc);
      check("burst4_busy_cycles", 64'(bc), 64'd4);
      check("burst4_done_pulses", 64'(dc), 64'd1);
      check("burst4_out", 64'(out), 64'h0F02);
      do_load(2'b10, 16'hFF00);
      run_burst(4'd15, 2'b10, bc, dc);
      check("clamp_busy_cycles", 64'(bc), 64'd8);
      check("clamp_out", 64'(out), 64'h0002);
      do_load(2'b10, 16'hA500);
      run_burst(4'd0, 2'b10, bc, dc);
      check("len0_busy_cycles", 64'(bc), 64'd0);
      check("len0_done_pulses", 64'(dc), 64'd1);
      check("len0_out", 64'(out), 64'hA502);
      do_load(2'b10, 16'hF000);
      burst_start = 1'b1; burst_len = 4'd4; shift = 2'b10;
      @(negedge clk); clr();
      repeat (2) @(negedge clk);
      check("run_two_steps", 64'(out[15:8]), 64'h3C);
      load = 2'b10; data = 16'h8100; @(negedge clk); load = '0;
      check("run_load_value", 64'(out[15:8]), 64'h81);
      check("run_load_busy", 64'(busy), 64'h1);
      @(negedge clk);
      check("run_after_load", 64'(out[15:8]), 64'h40);
      check("run_after_load_done", 64'(done), 64'h1);
      do_load(2'b11, 16'h33CC);
      burst_start = 1'b1; burst_len = 4'd8; shift = 2'b11;
      @(negedge clk); clr();
      repeat (2) @(negedge clk);
      rst = 1'b1; @(negedge clk);
      check("abort_out", 64'(out), 64'h0);
      check("abort_busy", 64'(busy), 64'h0);
      check("abort_done", 64'(done), 64'h0);
      rst = 1'b0; @(negedge clk);
      check("abort_no_done", 64'(done), 64'h0);
`ifdef SHREG_ROTATE_EN
      do_load(2'b01, 16'h0081);
      rotate = 1'b1; shift = 2'b01; @(negedge clk); clr();
      check("rotate_right", 64'(out[7:0]), 64'hC0);
`endif
      for (int k = 0; k < 400; k++) begin
         rst = ($urandom_range(0, 60) == 0);
         load = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0;
         data = 16'($urandom); shift = NUM_CH'($urandom); dir = NUM_CH'($urandom);
         cascade_en = 1'($urandom); serial_in = 1'($urandom);
         burst_start = ($urandom_range(0, 7) == 0); burst_len = 4'($urandom);
         rotate = ROT ? 1'($urandom) : 1'b0;
         @(negedge clk);
      end
      clr(); rst = 1'b0;
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
